// File: rtl/operand_fetch.sv
// Decode-stage operand fetch: drives register file read addresses, retries reads blocked
// by a writeback collision and hands both operands downstream. Bypass option: OPFETCH_BYPASS_EN.
module operand_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_pc,
  output logic [4:0]  rf_ra1,
  output logic [4:0]  rf_ra2,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
  input  logic        wb_we,
  input  logic [4:0]  wb_wa,
  input  logic [31:0] wb_wd,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_op1,
  output logic [31:0] out_op2,
  output logic [4:0]  out_rd,
  output logic [31:0] out_pc
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, VALID} state_t;

  state_t           state, state_nxt;
  logic [1:0][4:0]  src, ra, in_rs;
  logic [1:0][31:0] rdata, op;
  logic             collide, resolvable, accept, cap_rf, cap_byp;

  assign in_rs    = {in_rs2, in_rs1};
  assign rdata    = {rf_rd2, rf_rd1};
  assign in_ready = (state == IDLE);
  assign ra       = in_ready ? in_rs : src;
  assign rf_ra1   = ra[0];
  assign rf_ra2   = ra[1];
  assign out_op1  = op[0];
  assign out_op2  = op[1];

  // The register file drops both read ports when a write hits either read address.
  assign collide = wb_we && (wb_wa == ra[0] || wb_wa == ra[1]);
`ifdef OPFETCH_BYPASS_EN
  assign resolvable = collide && (ra[0] == wb_wa || ra[0] == 5'd0)
                              && (ra[1] == wb_wa || ra[1] == 5'd0);
`else
  assign resolvable = 1'b0;
`endif

  assign accept  = in_ready && in_valid && !flush;
  assign cap_rf  = (state == CAPTURE) && !flush;
  assign cap_byp = resolvable && !flush && (accept || state == ISSUE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = resolvable ? VALID : (collide ? ISSUE : CAPTURE);
      ISSUE:   state_nxt = resolvable ? VALID : (collide ? ISSUE : CAPTURE);
      CAPTURE: state_nxt = VALID;
      VALID:   if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      src       <= '0;
      op        <= '0;
      out_valid <= 1'b0;
      out_rd    <= '0;
      out_pc    <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt == VALID);
      if (accept) begin
        src    <= in_rs;
        out_rd <= in_rd;
        out_pc <= in_pc;
      end
      // Index 0 always reads as zero, whatever the array holds or the bypass carries.
      for (int i = 0; i < 2; i++) begin
        if (cap_rf)       op[i] <= (src[i] == 5'd0) ? 32'd0 : rdata[i];
        else if (cap_byp) op[i] <= (ra[i] == 5'd0) ? 32'd0 : wb_wd;
      end
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed vector table, flush/reset sequences and
// randomized transactions against a transaction-level latency/operand model.
module tb_operand_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_pc;
  logic [4:0]  rf_ra1, rf_ra2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        flush, out_valid, out_ready;
  logic [31:0] out_op1, out_op2, out_pc;
  logic [4:0]  out_rd;

  int total = 0;
  int bad = 0;

`ifdef OPFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_pc(in_pc),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2),
    .out_rd(out_rd), .out_pc(out_pc)
  );

  // Register file environment: synchronous read, both ports held on a write/read collision.
  logic [31:0] rf [32];
  always @(posedge clk) begin
    if (!(wb_we && (wb_wa == rf_ra1 || wb_wa == rf_ra2))) begin
      rf_rd1 <= rf[rf_ra1];
      rf_rd2 <= rf[rf_ra2];
    end
    if (wb_we) rf[wb_wa] <= wb_wd;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wb_we = 1'b1; wb_wa = a; wb_wd = d;
    @(negedge clk);
    wb_we = 1'b0;
  endtask

  // One instruction: accept, feed a writeback pattern, observe latency/operands, backpressure, handshake.
  task automatic run_txn(input logic [4:0] r1, input logic [4:0] r2, input int ncol,
                         input logic rand_wa, input logic [4:0] cwa, input logic [31:0] cwd,
                         input logic quiet, input int hold,
                         output int mlat, output logic [31:0] m1, output logic [31:0] m2,
                         output int olat, output logic [31:0] o1, output logic [31:0] o2);
    logic [4:0]  rd;
    logic [31:0] pc;
    rd = 5'($urandom); pc = $urandom;
    mlat = 0; olat = 0; m1 = '0; m2 = '0; o1 = '0; o2 = '0;
    @(negedge clk);
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_pc = pc;
    for (int k = 0; k < 12 && olat == 0; k++) begin
      if (mlat == 0 && k < ncol) begin
        wb_we = 1'b1;
        wb_wa = rand_wa ? ((($urandom & 1) != 0) ? r1 : r2) : cwa;
        wb_wd = cwd + 32'(k);
      end else if (quiet) begin
        wb_we = 1'b0;
      end else if (mlat == 0) begin
        wb_we = 1'($urandom);
        do wb_wa = 5'($urandom); while (wb_wa == r1 || wb_wa == r2);
        wb_wd = $urandom;
      end else begin
        wb_we = 1'($urandom); wb_wa = 5'($urandom); wb_wd = $urandom;
      end
      if (mlat == 0) begin
        if (wb_we && (wb_wa == r1 || wb_wa == r2)) begin
          if (BYP && (r1 == wb_wa || r1 == 5'd0) && (r2 == wb_wa || r2 == 5'd0)) begin
            mlat = k + 1;
            m1 = (r1 == 5'd0) ? 32'd0 : wb_wd;
            m2 = (r2 == 5'd0) ? 32'd0 : wb_wd;
          end
        end else begin
          mlat = k + 2;
          m1 = (r1 == 5'd0) ? 32'd0 : rf[r1];
          m2 = (r2 == 5'd0) ? 32'd0 : rf[r2];
        end
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_rs1 = 5'($urandom); in_rs2 = 5'($urandom); in_rd = 5'($urandom); in_pc = $urandom;
      if (out_valid) begin
        olat = k + 1; o1 = out_op1; o2 = out_op2;
        chk("out_rd", 32'(out_rd), 32'(rd));
        chk("out_pc", out_pc, pc);
      end
    end
    wb_we = 1'b0;
    if (olat == 0) begin
      total++; bad++;
      $display("FAIL out_valid_timeout: got never want latency %0d", mlat);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_op1", out_op1, o1);
      chk("hold_op2", out_op2, o2);
      chk("hold_pc", out_pc, pc);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_handshake_valid", 32'(out_valid), 32'd0);
    chk("post_handshake_in_ready", 32'(in_ready), 32'd1);
  endtask

  typedef struct {
    logic [4:0]  r1, r2;
    int          ncol;
    logic [4:0]  cwa;
    logic [31:0] cwd;
    int          lat;
    logic [31:0] op1, op2;
  } vec_t;

  vec_t vt [6];

  initial begin
    int ml, ol;
    logic [31:0] m1, m2, o1, o2;
    logic [4:0]  r1, r2;

    vt[0] = '{5'd5, 5'd6, 0, 5'd0, 32'h0,  2,            32'hAAAA, 32'h5555};
    vt[1] = '{5'd0, 5'd0, 0, 5'd0, 32'h0,  2,            32'h0,    32'h0};
    vt[2] = '{5'd3, 5'd9, 1, 5'd9, 32'h77, 3,            32'h33,   32'h77};
    vt[3] = '{5'd3, 5'd9, 2, 5'd9, 32'h77, 4,            32'h33,   32'h78};
    vt[4] = '{5'd9, 5'd0, 1, 5'd9, 32'h77, BYP ? 1 : 3,  32'h77,   32'h0};
    vt[5] = '{5'd0, 5'd0, 1, 5'd0, 32'h55, BYP ? 1 : 3,  32'h0,    32'h0};

    rst_n = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_pc = '0;
    wb_we = 1'b0; wb_wa = '0; wb_wd = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_op1", out_op1, 32'd0);
    chk("reset_op2", out_op2, 32'd0);
    chk("reset_rd", 32'(out_rd), 32'd0);
    chk("reset_pc", out_pc, 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) wr(5'(i), $urandom);
    wr(5'd5, 32'hAAAA); wr(5'd6, 32'h5555); wr(5'd0, 32'hFFFF);
    wr(5'd3, 32'h33);   wr(5'd9, 32'h99);   wr(5'd7, 32'h1234);

    // Reset asserted while VALID clears outputs asynchronously.
    @(negedge clk);
    in_valid = 1'b1; in_rs1 = 5'd7; in_rs2 = 5'd0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    chk("pre_reset_op1", out_op1, 32'h1234);
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 32'(out_valid), 32'd0);
    chk("async_reset_op1", out_op1, 32'd0);
    chk("async_reset_op2", out_op2, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 6; i++) begin
      run_txn(vt[i].r1, vt[i].r2, vt[i].ncol, 1'b0, vt[i].cwa, vt[i].cwd, 1'b1, i % 3,
              ml, m1, m2, ol, o1, o2);
      chk($sformatf("vec%0d_latency", i), 32'(ol), 32'(vt[i].lat));
      chk($sformatf("vec%0d_op1", i), o1, vt[i].op1);
      chk($sformatf("vec%0d_op2", i), o2, vt[i].op2);
    end

    // Backpressure for 5 cycles, then flush out of VALID.
    @(negedge clk);
    in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd6;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_valid", 32'(out_valid), 32'd1);
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_op1", out_op1, 32'hAAAA);
      chk("bp_hold_op2", out_op2, 32'h5555);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);

    // Flush together with in_valid in IDLE: instruction must not be taken.
    in_valid = 1'b1; in_rs1 = 5'd6; in_rs2 = 5'd5; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    chk("flush_idle_no_valid", 32'(out_valid), 32'd0);

    // Flush while retrying in ISSUE (collision held on the second edge too).
    in_valid = 1'b1; in_rs1 = 5'd3; in_rs2 = 5'd5;
    wb_we = 1'b1; wb_wa = 5'd3; wb_wd = 32'h44;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1;
    chk("issue_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0; wb_we = 1'b0;
    chk("flush_issue_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    chk("flush_issue_no_valid", 32'(out_valid), 32'd0);

    run_txn(5'd5, 5'd6, 0, 1'b0, 5'd0, 32'h0, 1'b1, 0, ml, m1, m2, ol, o1, o2);
    chk("after_flush_latency", 32'(ol), 32'd2);
    chk("after_flush_op1", o1, 32'hAAAA);
    chk("after_flush_op2", o2, 32'h5555);

    for (int i = 0; i < 60; i++) begin
      r1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      r2 = ($urandom_range(0, 3) == 0) ? 5'd0 : (($urandom_range(0, 4) == 0) ? r1 : 5'($urandom));
      run_txn(r1, r2, int'($urandom_range(0, 2)), 1'b1, 5'd0, $urandom, 1'b0,
              int'($urandom_range(0, 3)), ml, m1, m2, ol, o1, o2);
      chk($sformatf("rand%0d_latency", i), 32'(ol), 32'(ml));
      chk($sformatf("rand%0d_op1", i), o1, m1);
      chk($sformatf("rand%0d_op2", i), o2, m2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode-stage operand fetch initiator for the integer register file. Accepts one decoded instruction (rs1, rs2, rd, pc) on a valid/ready handshake and drives the register file read addresses. It captures the synchronous read data and presents both operands downstream on a second valid/ready handshake. It sits between the decoder and the execute stage and resolves the register file's write/read collision rule (read suppressed when a write targets either read address) by re-issuing the read, or optionally by bypassing the write data.

## Interface

- No parameters (XLEN fixed at 32, 32 registers).

- clk  in  1  core clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  unit can accept; high only in IDLE.
- in_rs1, in_rs2  in  5 each  source register indices.
- in_rd  in  5  destination index, passed through.
- in_pc  in  32  instruction PC, passed through.
- rf_ra1, rf_ra2  out  5 each  register file read addresses.
- rf_rd1, rf_rd2  in  32 each  register file read data, valid the cycle after the sampling edge.
- wb_we, wb_wa[4:0], wb_wd[31:0]  in  snoop of the writeback port driving the register file in the same cycle.
- flush  in  1  synchronous abort of the in-flight instruction.
- out_valid  out  1  operands valid.
- out_ready  in  1  execute stage accepts.
- out_op1, out_op2  out  32 each  operand values.
- out_rd  out  5; out_pc  out  32  pass-through.

## Operation

- States: IDLE, ISSUE, CAPTURE, VALID.
- Collision at an edge: wb_we && (wb_wa == rf_ra1 || wb_wa == rf_ra2), including index 0. The register file then updates neither read output.
- Address mux: rf_ra1/rf_ra2 = in_rs1/in_rs2 in IDLE, otherwise the latched rs1/rs2.
- IDLE: in_ready=1. On in_valid:
  - latch rs1, rs2, rd, pc.
  - Collision at this edge → ISSUE; else → CAPTURE.
- ISSUE: re-read with latched addresses. Collision → stay ISSUE; else → CAPTURE.
- CAPTURE: out_op1/out_op2 ← rf_rd1/rf_rd2. A source index of 0 forces 0 regardless of rf data. Then → VALID.
- VALID: out_valid=1, outputs held stable. On out_ready → IDLE.
- flush, any state, priority over all transitions: → IDLE, out_valid=0 next cycle. A same-edge in_valid in IDLE is not accepted.
- Reset: state IDLE; out_valid=0, out_op1/out_op2/out_pc=0, out_rd=0; in_ready=1 after reset release.

## Timing

- Accept edge E0 with no collision:
  - capture at E1.
  - out_valid high from E1 through the handshake edge.
  - Latency 2 edges; minimum issue interval 3 cycles (IDLE→CAPTURE→VALID→IDLE).
- Each collision edge adds exactly 1 cycle. Consecutive colliding writes stall indefinitely; there is no timeout.
- out_valid stays asserted while out_ready=0; out_op*/out_rd/out_pc do not change.
- Only the rf_ra* address mux is combinational; in_ready is decoded directly from state. All other outputs are registered.

## Configuration

- OPFETCH_BYPASS_EN defined: a collision is resolvable if every source is either wb_wa or 0.
  - Resolvable collision, at either the IDLE accept edge or in ISSUE → go directly to VALID.
  - Matching operands take wb_wd; index-0 operands take 0. When wb_wa=0, index-0 operands still take 0.
  - Latency 1 edge.
  - A non-resolvable collision follows the retry path.
- Undefined: every collision retries via ISSUE; there is no bypass datapath.

## Test plan

- Reset mid-VALID (out_op1=0x1234): assert rst_n=0 → out_valid=0 and out_op*=0 immediately; in_ready=1 after release.
- No collision: x5=0xAAAA, x6=0x5555; issue rs1=5, rs2=6, out_ready=1 → out_valid 2 edges after accept, op1=0xAAAA, op2=0x5555.
- Zero source: issue rs1=0, rs2=0 with x0 previously written 0xFFFF → op1=op2=0.
- Collision retry (macro off): accept rs1=3, rs2=9 while wb_we=1, wb_wa=9, wb_wd=0x77 → one ISSUE cycle, then op2=0x77, total latency 3. Repeat with two consecutive colliding writes → latency 4.
- Bypass (macro on): accept rs1=9, rs2=0 with wb_wa=9, wb_wd=0x77 → out_valid after 1 edge, op1=0x77, op2=0. With rs1=9, rs2=3 → retry path, latency 3.
- Backpressure and flush: hold out_ready=0 for 5 cycles → outputs stable, in_ready=0. Pulse flush → out_valid=0 next cycle, state IDLE, the next instruction is accepted normally.
